// File: rtl/oagu_tile_sched.sv
// oagu_tile_sched
//   Tile scheduler for the Oagu output path. Runs a layer as cfg_tile_num
//   output tiles, ping-ponging the two IO-buffer halves. Each tile is
//   programmed through buffer_flag/addr_start_s and started with a
//   start_calculate pulse. Each finished half is handed to the drain engine,
//   and a half is reused only after its drain_done.
//
//   Ports
//     clk, rst                  clock, synchronous active-high reset
//     layer_start, cfg_*        layer launch pulse and its configuration
//     busy, layer_done          layer in progress / layer completion pulse
//     start_calculate           one-cycle tile start to Oagu
//     buffer_flag               [0] target half, [1] last-tile marker
//     addr_start_s              Oagu store base for the current tile
//     calculate_end             one-cycle tile-written pulse from Oagu
//     drain_req, drain_buf      write-back request for a full half
//     drain_ack, drain_done     drain engine accept / half-free pulses
//     wdog_err                  sticky watchdog error
//
//   Build option
//     OAGU_SCHED_WDOG_EN        enables the CALC watchdog (WDOG_CYC cycles);
//                               without it wdog_err stays 0.
module oagu_tile_sched #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned TILE_W   = 8,
    parameter int unsigned WDOG_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              layer_start,
    input  logic [TILE_W-1:0] cfg_tile_num,
    input  logic [ADDR_W-1:0] cfg_addr_base,
    input  logic [ADDR_W-1:0] cfg_tile_stride,
    output logic              busy,
    output logic              layer_done,
    output logic              start_calculate,
    output logic [1:0]        buffer_flag,
    output logic [ADDR_W-1:0] addr_start_s,
    input  logic              calculate_end,
    output logic              drain_req,
    output logic              drain_buf,
    input  logic              drain_ack,
    input  logic              drain_done,
    output logic              wdog_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BUF,
        S_ISSUE,
        S_CALC,
        S_FINISH
    } state_e;

    // The watchdog counter needs at least one count before CALC starts.
    if (WDOG_CYC < 2) begin : g_wdog_cfg_chk
        $error("oagu_tile_sched: WDOG_CYC must be at least 2");
    end

    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              layer_done_q, layer_done_d;
    logic              start_calc_q, start_calc_d;
    logic [1:0]        buffer_flag_q, buffer_flag_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [TILE_W-1:0] tile_num_q, tile_num_d;
    logic [TILE_W-1:0] tile_cnt_q, tile_cnt_d;
    logic [1:0]        full_q, full_d;
    logic              cur_q, cur_d;
    logic              dptr_q, dptr_d;
    logic              inflight_q, inflight_d;
    logic              drain_req_q, drain_req_d;
    logic              drain_buf_q, drain_buf_d;
    logic              wdog_err_q, wdog_err_d;
    logic              last_c;
    logic              wdog_trip_c;

`ifdef OAGU_SCHED_WDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYC);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;

    // Counts from the ISSUE cycle so the trip lands WDOG_CYC cycles after the start pulse.
    always_comb begin
        wdog_cnt_d  = '0;
        wdog_trip_c = 1'b0;
        if (state_q == S_ISSUE) begin
            wdog_cnt_d = WDOG_W'(1);
        end else if (state_q == S_CALC && !calculate_end) begin
            if (wdog_cnt_q == WDOG_W'(WDOG_CYC - 1)) begin
                wdog_trip_c = 1'b1;
            end else begin
                wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt_q <= '0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
        end
    end
`else
    assign wdog_trip_c = 1'b0;
`endif

    assign last_c = (tile_cnt_q == (tile_num_q - TILE_W'(1)));

    // Next-state, drain bookkeeping and registered-output computation.
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        layer_done_d  = 1'b0;
        start_calc_d  = 1'b0;
        buffer_flag_d = buffer_flag_q;
        addr_d        = addr_q;
        stride_d      = stride_q;
        tile_num_d    = tile_num_q;
        tile_cnt_d    = tile_cnt_q;
        full_d        = full_q;
        cur_d         = cur_q;
        dptr_d        = dptr_q;
        inflight_d    = inflight_q;
        wdog_err_d    = wdog_err_q;

        // Drain side runs independently of the tile FSM.
        if (drain_req_q && drain_ack) begin
            inflight_d = 1'b1;
        end
        if (drain_done && inflight_q) begin
            full_d[dptr_q] = 1'b0;
            dptr_d         = ~dptr_q;
            inflight_d     = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (layer_start) begin
                    tile_num_d = cfg_tile_num;
                    addr_d     = cfg_addr_base;
                    stride_d   = cfg_tile_stride;
                    tile_cnt_d = '0;
                    cur_d      = 1'b0;
                    dptr_d     = 1'b0;
                    busy_d     = 1'b1;
                    wdog_err_d = 1'b0;
                    state_d    = (cfg_tile_num == '0) ? S_FINISH : S_WAIT_BUF;
                end
            end
            S_WAIT_BUF: begin
                if (!full_q[cur_q]) begin
                    start_calc_d  = 1'b1;
                    buffer_flag_d = {last_c, cur_q};
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CALC;
            end
            S_CALC: begin
                if (calculate_end) begin
                    full_d[cur_q] = 1'b1;
                    cur_d         = ~cur_q;
                    addr_d        = addr_q + stride_q;
                    tile_cnt_d    = tile_cnt_q + TILE_W'(1);
                    state_d       = last_c ? S_FINISH : S_WAIT_BUF;
                end else if (wdog_trip_c) begin
                    // Abort the layer: drop buffer ownership, no layer_done.
                    wdog_err_d = 1'b1;
                    busy_d     = 1'b0;
                    full_d     = 2'b00;
                    dptr_d     = 1'b0;
                    inflight_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_FINISH: begin
                if (full_q == 2'b00) begin
                    layer_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        drain_req_d = full_d[dptr_d] & ~inflight_d;
        drain_buf_d = dptr_d;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            layer_done_q  <= 1'b0;
            start_calc_q  <= 1'b0;
            buffer_flag_q <= 2'b00;
            addr_q        <= '0;
            stride_q      <= '0;
            tile_num_q    <= '0;
            tile_cnt_q    <= '0;
            full_q        <= 2'b00;
            cur_q         <= 1'b0;
            dptr_q        <= 1'b0;
            inflight_q    <= 1'b0;
            drain_req_q   <= 1'b0;
            drain_buf_q   <= 1'b0;
            wdog_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            layer_done_q  <= layer_done_d;
            start_calc_q  <= start_calc_d;
            buffer_flag_q <= buffer_flag_d;
            addr_q        <= addr_d;
            stride_q      <= stride_d;
            tile_num_q    <= tile_num_d;
            tile_cnt_q    <= tile_cnt_d;
            full_q        <= full_d;
            cur_q         <= cur_d;
            dptr_q        <= dptr_d;
            inflight_q    <= inflight_d;
            drain_req_q   <= drain_req_d;
            drain_buf_q   <= drain_buf_d;
            wdog_err_q    <= wdog_err_d;
        end
    end

    assign busy            = busy_q;
    assign layer_done      = layer_done_q;
    assign start_calculate = start_calc_q;
    assign buffer_flag     = buffer_flag_q;
    assign addr_start_s    = addr_q;
    assign drain_req       = drain_req_q;
    assign drain_buf       = drain_buf_q;
    assign wdog_err        = wdog_err_q;

endmodule

// File: tb/tb_oagu_tile_sched.sv
// tb_oagu_tile_sched
//   Self-checking bench for oagu_tile_sched. Oagu and drain-engine device
//   models respond to the DUT; an event-level reference model predicts every
//   output from the scheduling rules (tile addresses, ping-pong order, start
//   and completion timing relative to calculate_end / drain_done).
module tb_oagu_tile_sched;

    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned TILE_W  = 8;
    localparam int          WDOG_TB = 16;

    logic              clk;
    logic              rst;
    logic              layer_start;
    logic [TILE_W-1:0] cfg_tile_num;
    logic [ADDR_W-1:0] cfg_addr_base;
    logic [ADDR_W-1:0] cfg_tile_stride;
    logic              busy;
    logic              layer_done;
    logic              start_calculate;
    logic [1:0]        buffer_flag;
    logic [ADDR_W-1:0] addr_start_s;
    logic              calculate_end;
    logic              drain_req;
    logic              drain_buf;
    logic              drain_ack;
    logic              drain_done;
    logic              wdog_err;

    oagu_tile_sched #(
        .ADDR_W   (ADDR_W),
        .TILE_W   (TILE_W),
        .WDOG_CYC (WDOG_TB)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .layer_start     (layer_start),
        .cfg_tile_num    (cfg_tile_num),
        .cfg_addr_base   (cfg_addr_base),
        .cfg_tile_stride (cfg_tile_stride),
        .busy            (busy),
        .layer_done      (layer_done),
        .start_calculate (start_calculate),
        .buffer_flag     (buffer_flag),
        .addr_start_s    (addr_start_s),
        .calculate_end   (calculate_end),
        .drain_req       (drain_req),
        .drain_buf       (drain_buf),
        .drain_ack       (drain_ack),
        .drain_done      (drain_done),
        .wdog_err        (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n   = 0;

    // Reference model state (per layer)
    bit              m_busy = 1'b0;
    bit              m_wdog = 1'b0;
    int              m_n    = 0;
    logic [ADDR_W-1:0] m_base   = '0;
    logic [ADDR_W-1:0] m_stride = '0;
    int              m_acc      = 0;
    int              n_start    = 0;
    int              n_acc      = 0;
    int              last_start = 0;
    int              ce_q[$];
    int              dn_q[$];
    bit              prev_req   = 1'b0;

    // Device model state and knobs
    bit oagu_en   = 1'b1;
    int oagu_due  = -1;
    int ack_due   = -1;
    int done_due  = -1;
    bit dma_busy  = 1'b0;
    int lat_min   = 10;
    int lat_max   = 10;
    int ack_max   = 1;
    int done_min  = 5;
    int done_max  = 5;
    int first_done_dly = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic logic [ADDR_W-1:0] exp_addr(input int i);
        return ADDR_W'(32'(m_base) + 32'(i) * 32'(m_stride));
    endfunction

    function automatic logic [1:0] exp_flag(input int i);
        logic [1:0] f;
        f[1] = (i == m_n - 1);
        f[0] = i[0];
        return f;
    endfunction

    task automatic model_clear();
        ce_q.delete();
        dn_q.delete();
        n_acc    = 0;
        n_start  = 0;
        oagu_due = -1;
        ack_due  = -1;
        done_due = -1;
        dma_busy = 1'b0;
    endtask

    // Apply the inputs sampled at edge_n to the model and compare all outputs.
    task automatic evaluate();
        int  e_now;
        int  ends;
        int  dones;
        int  i;
        int  e;
        bit  inflight_before;
        bit  ce_eff;
        bit  dd_eff;
        bit  ack_eff;
        bit  exp_start;
        bit  exp_done;
        bit  exp_req;
        e_now = edge_n;
        if (rst) begin
            m_busy = 1'b0;
            m_wdog = 1'b0;
            model_clear();
            check("rst_busy",   32'(busy),            32'd0);
            check("rst_done",   32'(layer_done),      32'd0);
            check("rst_start",  32'(start_calculate), 32'd0);
            check("rst_flag",   32'(buffer_flag),     32'd0);
            check("rst_addr",   32'(addr_start_s),    32'd0);
            check("rst_dreq",   32'(drain_req),       32'd0);
            check("rst_dbuf",   32'(drain_buf),       32'd0);
            check("rst_wdog",   32'(wdog_err),        32'd0);
            prev_req = drain_req;
            return;
        end

        inflight_before = (n_acc > dn_q.size());
        ce_eff  = calculate_end && (n_start > ce_q.size()) && (e_now >= last_start + 2);
        dd_eff  = drain_done && inflight_before;
        ack_eff = drain_ack && prev_req;

        if (layer_start && !m_busy) begin
            model_clear();
            m_n      = int'(cfg_tile_num);
            m_base   = cfg_addr_base;
            m_stride = cfg_tile_stride;
            m_acc    = e_now;
            m_busy   = 1'b1;
            m_wdog   = 1'b0;
        end
        if (oagu_due == e_now) oagu_due = -1;
        if (ce_eff) ce_q.push_back(e_now);
        if (ack_eff) begin
            n_acc++;
            dma_busy = 1'b1;
            if (n_acc == 1 && first_done_dly > 0) done_due = e_now + first_done_dly;
            else done_due = e_now + int'($urandom_range(done_min, done_max));
        end
        if (ack_due >= 0 && ack_due <= e_now) ack_due = -1;
        if (done_due == e_now) done_due = -1;
        if (dd_eff) begin
            dn_q.push_back(e_now);
            dma_busy = 1'b0;
        end
`ifdef OAGU_SCHED_WDOG_EN
        if (!ce_eff && m_busy && n_start > ce_q.size() && e_now == last_start + WDOG_TB) begin
            m_busy = 1'b0;
            m_wdog = 1'b1;
            model_clear();
        end
`endif

        ends  = ce_q.size();
        dones = dn_q.size();
        i     = n_start;
        exp_start = 1'b0;
        if (m_busy && i < m_n) begin
            if (i == 0) begin
                exp_start = (e_now == m_acc + 1);
            end else if (ends >= i && (i < 2 || dones >= i - 1)) begin
                e = ce_q[i-1] + 1;
                if (i >= 2 && dn_q[i-2] + 1 > e) e = dn_q[i-2] + 1;
                exp_start = (e_now == e);
            end
        end
        check("start_calculate", 32'(start_calculate), 32'(exp_start));
        if (exp_start) begin
            check("addr_start_s", 32'(addr_start_s), 32'(exp_addr(i)));
            check("buffer_flag",  32'(buffer_flag),  32'(exp_flag(i)));
            last_start = e_now;
            n_start++;
        end

        exp_done = m_busy && ((m_n == 0 && e_now == m_acc + 1) ||
                              (m_n > 0 && dones == m_n && e_now == dn_q[m_n-1] + 1));
        if (exp_done) m_busy = 1'b0;
        check("layer_done", 32'(layer_done), 32'(exp_done));
        check("busy",       32'(busy),       32'(m_busy));

        exp_req = (ends > dones) && (n_acc <= dones);
        check("drain_req", 32'(drain_req), 32'(exp_req));
        if (exp_req) check("drain_buf", 32'(drain_buf), 32'(dones[0]));
        check("wdog_err", 32'(wdog_err), 32'(m_wdog));
        prev_req = drain_req;
    endtask

    // Device models: compute Oagu / drain-engine inputs for the next edge.
    task automatic drive();
        calculate_end = 1'b0;
        drain_ack     = 1'b0;
        drain_done    = 1'b0;
        if (start_calculate && oagu_en) oagu_due = edge_n + int'($urandom_range(lat_min, lat_max));
        if (oagu_due == edge_n + 1) begin
            if (n_start > 0) begin
                check("addr_hold", 32'(addr_start_s), 32'(exp_addr(n_start - 1)));
                check("flag_hold", 32'(buffer_flag),  32'(exp_flag(n_start - 1)));
            end
            calculate_end = 1'b1;
        end
        if (drain_req && !dma_busy && ack_due < 0) ack_due = edge_n + int'($urandom_range(1, ack_max));
        if (ack_due == edge_n + 1) drain_ack = 1'b1;
        if (done_due == edge_n + 1) drain_done = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        evaluate();
        layer_start = 1'b0;
        drive();
    endtask

    task automatic run_layer(input int n, input logic [ADDR_W-1:0] base,
                             input logic [ADDR_W-1:0] stride, input bit inject);
        int budget;
        int inj_at;
        cfg_tile_num    = TILE_W'(n);
        cfg_addr_base   = base;
        cfg_tile_stride = stride;
        layer_start     = 1'b1;
        step();
        inj_at = int'($urandom_range(1, 30));
        budget = 3000;
        while (m_busy && budget > 0) begin
            if (inject && budget == 3000 - inj_at) begin
                cfg_tile_num    = TILE_W'($urandom_range(0, 7));
                cfg_addr_base   = ADDR_W'($urandom);
                cfg_tile_stride = ADDR_W'($urandom);
                layer_start     = 1'b1;
            end
            step();
            budget--;
        end
        if (budget == 0) check("layer_timeout", 32'(m_busy), 32'd0);
        repeat (2) step();
    endtask

    initial begin
        rst             = 1'b1;
        layer_start     = 1'b0;
        cfg_tile_num    = '0;
        cfg_addr_base   = '0;
        cfg_tile_stride = '0;
        calculate_end   = 1'b0;
        drain_ack       = 1'b0;
        drain_done      = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Nominal three-tile layer
        run_layer(3, 12'h000, 12'h024, 1'b0);

        // First ping drain withheld: third tile waits for the half
        first_done_dly = 50;
        run_layer(3, 12'h100, 12'h024, 1'b0);
        first_done_dly = 0;

        // Address wrap
        run_layer(2, 12'hFF0, 12'h010, 1'b0);

        // Empty layer
        run_layer(0, 12'h123, 12'h045, 1'b0);

        // Reset mid-CALC, stray handshakes, then a fresh single-tile layer
        cfg_tile_num    = TILE_W'(3);
        cfg_addr_base   = 12'h200;
        cfg_tile_stride = 12'h010;
        layer_start     = 1'b1;
        step();
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        calculate_end = 1'b1;
        drain_done    = 1'b1;
        step();
        repeat (3) step();
        run_layer(1, 12'h080, 12'h040, 1'b0);

`ifdef OAGU_SCHED_WDOG_EN
        // Silent Oagu trips the watchdog; the next layer clears the error
        oagu_en = 1'b0;
        run_layer(2, 12'h300, 12'h040, 1'b0);
        oagu_en = 1'b1;
        run_layer(2, 12'h300, 12'h040, 1'b0);
`endif

        // Randomized layers with random latencies and spurious layer_start
        repeat (30) begin
            lat_min  = 2;
            lat_max  = int'($urandom_range(2, 14));
            ack_max  = int'($urandom_range(1, 4));
            done_min = 1;
            done_max = int'($urandom_range(1, 20));
            first_done_dly = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 40)) : 0;
            run_layer(int'($urandom_range(0, 6)), ADDR_W'($urandom), ADDR_W'($urandom),
                      1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
